// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the second-order sigma-delta DAC.
// The dither LFSR constants are only consumed when SDM_DAC_DITHER_EN is defined.
package sdm_pkg;

    localparam int DW_DEF = 18;
    localparam int AW_DEF = 22;
    localparam int FS     = 1 << (DW_DEF - 1);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Clamp a signed value into the range of a width-bit two's complement word.
    function automatic longint saturate(input longint value, input int width,
                                        output logic clipped);
        longint hi;
        longint lo;
        longint res;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        clipped = 1'b0;
        res = value;
        if (value > hi) begin
            res = hi;
            clipped = 1'b1;
        end else if (value < lo) begin
            res = lo;
            clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdm_dac_lfsr16.sv
// 16-bit Fibonacci LFSR used as the dither source (taps 16,14,13,11).
module lfsr16
    import sdm_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/sdm_dac.sv
// Second-order sigma-delta modulator producing a 1-bit pulse-density stream.
// Define SDM_DAC_DITHER_EN to add a small LFSR dither term into the first integrator.
module sdm_dac
    import sdm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          endataout,
    input  logic [DW-1:0] datain,
    input  logic          mute,
    input  logic          clr_ovl,
    output logic          dout,
    output logic          ovl
);

    localparam logic [AW:0] FB_POS = (AW+1)'(longint'(1) << (DW - 1));
    localparam logic [AW:0] FB_NEG = (AW+1)'(-(longint'(1) << (DW - 1)));

    logic signed [DW-1:0] x_q;
    logic signed [AW-1:0] i1;
    logic signed [AW-1:0] i2;
    logic signed [AW-1:0] i1_next;
    logic signed [AW-1:0] i2_next;
    logic signed [AW:0]   sum1;
    logic signed [AW:0]   sum2;
    logic        [AW:0]   xin_ext;
    logic        [AW:0]   fb_ext;
    logic        [AW:0]   d_ext;
    logic                 clip1;
    logic                 clip2;

`ifdef SDM_DAC_DITHER_EN
    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign d_ext = {{(AW-3){lfsr_q[3]}}, lfsr_q[3:0]};
`else
    assign d_ext = '0;
`endif

    // Sums are one bit wider than the integrators so the clip test sees true overflow.
    always_comb begin
        xin_ext = mute ? '0 : {{(AW+1-DW){x_q[DW-1]}}, x_q};
        fb_ext  = dout ? FB_POS : FB_NEG;
        sum1    = {i1[AW-1], i1} + xin_ext - fb_ext + d_ext;
        sum2    = {i2[AW-1], i2} + {i1[AW-1], i1} - fb_ext;
        clip1   = 1'b0;
        clip2   = 1'b0;
        i1_next = AW'(saturate(longint'(sum1), AW, clip1));
        i2_next = AW'(saturate(longint'(sum2), AW, clip2));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q  <= '0;
            i1   <= '0;
            i2   <= '0;
            dout <= 1'b0;
            ovl  <= 1'b0;
        end else begin
            if (endataout) begin
                x_q <= datain;
            end
            i1   <= i1_next;
            i2   <= i2_next;
            dout <= !i2_next[AW-1];
            if (clip1 || clip2) begin
                ovl <= 1'b1;
            end else if (clr_ovl) begin
                ovl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdm_dac.sv
// Randomized self-checking bench for sdm_dac against an arithmetic loop model.
// Build with SDM_DAC_DITHER_EN defined to also track the dither LFSR.
module tb_sdm_dac;

    localparam longint FSV = 131072;
    localparam longint LIM = 2097152;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        endataout = 1'b0;
    logic [17:0] datain = '0;
    logic        mute = 1'b0;
    logic        clr_ovl = 1'b0;
    logic        dout;
    logic        ovl;

    int total_count = 0;
    int bad_count = 0;

    longint m_xq, m_i1, m_i2;
    bit     m_dout, m_ovl, m_clip;
    int     m_lfsr;

    sdm_dac dut (
        .clock     (clock),
        .reset     (reset),
        .endataout (endataout),
        .datain    (datain),
        .mute      (mute),
        .clr_ovl   (clr_ovl),
        .dout      (dout),
        .ovl       (ovl)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total_count++;
        if (observed != expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic longint clampTo(input longint v, output bit clipped);
        clipped = (v > LIM - 1) || (v < -LIM);
        if (v > LIM - 1) return LIM - 1;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic longint inRange(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelReset();
        m_xq = 0; m_i1 = 0; m_i2 = 0;
        m_dout = 0; m_ovl = 0; m_clip = 0;
        m_lfsr = 'hACE1;
    endtask

    // One clock of the loop, using the inputs present at the edge.
    task automatic modelStep();
        longint xin, fb, d, s1, s2, n1, n2;
        bit c1, c2;
        int fbit;
        xin = mute ? 0 : m_xq;
        fb = m_dout ? FSV : -FSV;
        d = 0;
`ifdef SDM_DAC_DITHER_EN
        d = longint'(m_lfsr % 16);
        if (d > 7) d = d - 16;
`endif
        s1 = m_i1 + xin - fb + d;
        s2 = m_i2 + m_i1 - fb;
        n1 = clampTo(s1, c1);
        n2 = clampTo(s2, c2);
        m_clip = c1 | c2;
        if (m_clip) m_ovl = 1;
        else if (clr_ovl) m_ovl = 0;
        m_dout = (n2 >= 0);
        m_i1 = n1;
        m_i2 = n2;
        if (endataout) m_xq = longint'($signed(datain));
        fbit = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fbit << 15);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) modelReset();
        else modelStep();
        #1;
        checkOutput("dout", longint'(dout), longint'(m_dout));
        checkOutput("ovl", longint'(ovl), longint'(m_ovl));
        checkOutput("i1", longint'(dut.i1), m_i1);
        checkOutput("i2", longint'(dut.i2), m_i2);
`ifdef SDM_DAC_DITHER_EN
        checkOutput("lfsr", longint'(dut.u_lfsr.q), longint'(m_lfsr));
`endif
    endtask

    task automatic applyStimulus(input logic [17:0] v);
        datain = v;
        endataout = 1'b1;
        tick();
        endataout = 1'b0;
    endtask

    // Asserts reset between edges and checks it takes effect without a clock.
    task automatic applyReset();
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_dout", longint'(dout), 0);
        checkOutput("async_ovl", longint'(ovl), 0);
        checkOutput("async_i1", longint'(dut.i1), 0);
        checkOutput("async_i2", longint'(dut.i2), 0);
`ifdef SDM_DAC_DITHER_EN
        checkOutput("async_lfsr", longint'(dut.u_lfsr.q), 'hACE1);
`endif
    endtask

    task automatic countOnes(input string tag, input int n, input longint lo, input longint hi);
        longint ones = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            ones += longint'(dout);
        end
        checkOutput(tag, ones, inRange(ones, lo, hi));
    endtask

    initial begin
        longint tol;
        int quiet;
        int v;
`ifdef SDM_DAC_DITHER_EN
        tol = 20;
`else
        tol = 4;
`endif
        modelReset();

        for (int k = 0; k < 16; k++) begin
            endataout = 1'($urandom_range(1));
            datain = 18'($urandom);
            mute = 1'($urandom_range(1));
            clr_ovl = 1'($urandom_range(1));
            tick();
        end

        endataout = 0; datain = '0; mute = 0; clr_ovl = 0;
        reset = 1'b1;
        tick();
`ifdef SDM_DAC_DITHER_EN
        checkOutput("rel_i1", longint'(dut.i1), FSV + 1);
`else
        checkOutput("rel_i1", longint'(dut.i1), FSV);
`endif
        checkOutput("rel_i2", longint'(dut.i2), FSV);
        checkOutput("rel_dout", longint'(dout), 1);

        countOnes("zero_ones", 4096, 2048 - tol, 2048 + tol);
        checkOutput("zero_ovl", longint'(ovl), 0);

        applyStimulus(18'sd65536);
        countOnes("dc_pos_ones", 4096, 3072 - 20, 3072 + 20);
        applyStimulus(-18'sd65536);
        countOnes("dc_neg_ones", 4096, 1024 - 20, 1024 + 20);
        checkOutput("dc_ovl", longint'(ovl), 0);

        applyStimulus(-18'sd131072);
        for (int k = 0; k < 2000; k++) tick();
        checkOutput("ovl_sat", longint'(ovl), 1);
        clr_ovl = 1'b1;
        tick();
        clr_ovl = 1'b0;
        checkOutput("ovl_clr_sat", longint'(ovl), 1);

        mute = 1'b1;
        applyStimulus(18'd0);
        quiet = 0;
        for (int k = 0; k < 3000 && quiet < 64; k++) begin
            tick();
            quiet = m_clip ? 0 : quiet + 1;
        end
        clr_ovl = 1'b1;
        tick();
        clr_ovl = 1'b0;
        if (quiet >= 64) checkOutput("ovl_recover", longint'(ovl), 0);
        mute = 1'b0;

        applyReset();
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        countOnes("zero_ones_2", 4096, 2048 - tol, 2048 + tol);

        for (int n = 0; n < 3000; n++) begin
            endataout = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) begin
                datain = 18'($urandom);
            end else begin
                v = int'($urandom_range(160000)) - 80000;
                datain = 18'(v);
            end
            mute = ($urandom_range(15) == 0);
            clr_ovl = ($urandom_range(15) == 0);
            tick();
            if (n == 1500) begin
                applyReset();
                tick();
                tick();
                reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/sdm_dac.md
# sdm_dac

Second-order sigma-delta modulator that turns the interpolator's 18-bit signed output stream into a 1-bit pulse-density stream at full clock rate, ready to drive an RC-filtered pin. It sits directly downstream of `interpol`. It samples `dataout` on the same `endataout` strobe that paces the interpolator, then runs the noise-shaping loop on every clock.

## Interface
- `DW`, 18, input sample width (signed, two's complement)
- `AW`, 22, integrator width (signed; must be ≥ DW+3)
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `endataout`  in  1  sample strobe, one clock wide, from the rate generator
- `datain`  in  DW  signed sample (`interpol.dataout`), valid when `endataout`=1
- `mute`  in  1  synchronous; forces the loop input to 0
- `clr_ovl`  in  1  synchronous clear of `ovl`
- `dout`  out  1  pulse-density output (1 = +FS, 0 = −FS)
- `ovl`  out  1  sticky integrator-saturation flag

## Operation
- Definitions:
  - FS = 2^(DW−1) = 131072.
  - `x_q` is the held input register.
  - `fb` = `dout` ? +FS : −FS.
- Input hold: `x_q` <= `datain` when `endataout`=1, otherwise it keeps its value. The loop input is `xin` = `mute` ? 0 : `x_q`.
- The loop runs every clock, independent of `endataout`. All sums are sign-extended to AW+1 bits, then saturated to [−2^(AW−1), 2^(AW−1)−1]:
  - `i1` <= sat(`i1` + `xin` − `fb`)
  - `i2` <= sat(`i2` + `i1` − `fb`), using the current (old) `i1`
  - `dout` <= (i2_next ≥ 0), where i2_next is the saturated value being written to `i2`
- Overload:
  - `ovl` <= 1 whenever either integrator sum is clipped in a cycle.
  - Otherwise `ovl` <= 0 when `clr_ovl`=1.
  - If saturation and `clr_ovl` happen in the same cycle, set wins.
- Reset values: `x_q`=0, `i1`=0, `i2`=0, `dout`=0, `ovl`=0, LFSR = seed (if present).
- No state machine. The block is a fixed two-integrator loop with one feedback register (`dout`).

## Timing
- `datain` to first effect on `i1`: 1 clock after the `endataout` edge (the `x_q` register stage).
- `datain` to first effect on `dout`: 3 clocks (`x_q` → `i1` → `i2`/`dout`).
- `dout` and `ovl` are registered outputs with no combinational path from inputs.
- `mute` and `clr_ovl` act on the next rising edge.
- `endataout` may arrive at any rate ≤ fclk; back-to-back strobes are legal.
- Reset asserted mid-stream: all state returns to reset values asynchronously. Operation resumes on the first edge after deassertion, with `fb` = −FS.

## Configuration
- Macro: `SDM_DAC_DITHER_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every clock.
  - Its 4 LSBs, as a signed value in −8..+7, are added into the `i1` sum: `i1` <= sat(`i1` + `xin` − `fb` + `d`).
  - The LFSR resets to the seed.
- Undefined: no LFSR logic is generated and d = 0. Behaviour is exactly as in Operation.

## Structure
- Shared package `sdm_pkg` holds:
  - the FS constant
  - the default DW and AW
  - a saturate function (AW+1 → AW bits, returning the clip flag)
  - the LFSR seed/tap constants
- One sub-module: `lfsr16`, with ports `clock`, `reset`, `q[15:0]`. It is instantiated only under `SDM_DAC_DITHER_EN`.

## Test plan
- Reset check: hold `reset`=0 and toggle inputs → `dout`=0, `ovl`=0, and `i1`/`i2`=0 throughout. Release reset with `datain`=0 → first edge gives `i1`=131072, `i2`=131072, `dout`=1.
- Zero input: `x`=0 for 4096 clocks (dither off) → ones count in 2048±4, `ovl`=0.
- DC input: `x`=+65536 (0.5 FS) via one `endataout` pulse, then 4096 clocks → ones density 0.75±0.005. `x`=−65536 → 0.25±0.005.
- Latency: step `datain` 0 → +65536 on `endataout` at edge N → `i1` changes first at edge N+1, and `dout` pattern deviates from the zero-input run no earlier than edge N+2.
- Overload: hold `x`=−131072 (−FS) for 2000 clocks → `ovl` rises and stays 1. Pulse `clr_ovl` while saturating → `ovl` stays 1. Set `x`=0, `mute`=1, wait for recovery, pulse `clr_ovl` → `ovl`=0 next edge.
- Dither (`SDM_DAC_DITHER_EN` defined): `x`=0 → LFSR sequence from 16'hACE1 matches the reference model, and ones density stays 0.5±0.005. Reset mid-run → LFSR returns to 16'hACE1.
